// File: rtl/bus_cycle_controller.sv
// Bus cycle sequencer: arbitrates EU transfers against prefetch and
// steps each transfer through T1..T4 (with waits). Tracks queue fill.
//
// Ports:
//   clk, reset           clock, async active-low reset
//   eu_req/eu_wr/eu_op   EU transfer request, direction, addressing mode
//   ready                memory ready, sampled in T3/TW
//   q_pop/q_flush        queue byte consumed / control transfer
//   alu_op               address ALU mode (0 = CS:IP for fetches)
//   q_en, ip_en, ip_sel  queue write, IP enable, IP load(1)/incr(0)
//   internal_rd_wr       buffer drives bus (EU write data phase)
//   ale, eu_ack          address strobe (T1), EU completion (T4)
//   bus_state            state code IDLE=0 T1=1 T2=2 T3=3 TW=4 T4=5
//   q_count/full/empty   queue occupancy 0..4 and flags
module bus_cycle_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic       eu_req,
   input  logic       eu_wr,
   input  logic [2:0] eu_op,
   input  logic       ready,
   input  logic       q_pop,
   input  logic       q_flush,
   output logic [2:0] alu_op,
   output logic       q_en,
   output logic       ip_en,
   output logic       ip_sel,
   output logic       internal_rd_wr,
   output logic       ale,
   output logic       eu_ack,
   output logic [2:0] bus_state,
   output logic [2:0] q_count,
   output logic       q_full,
   output logic       q_empty
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T1   = 3'd1,
      S_T2   = 3'd2,
      S_T3   = 3'd3,
      S_TW   = 3'd4,
      S_T4   = 3'd5
   } state_t;

   state_t     state;
   state_t     state_nxt;

   // attributes of the transfer currently on the bus
   logic       cyc_fetch;
   logic       cyc_wr;
   logic [2:0] cyc_op;
   logic       cyc_discard;

   logic       flush_eff;
   logic       push;
   logic       pop;
   logic [2:0] cnt_nxt;
   logic       eu_pend;
   logic       fetch_pend;
   logic       start;
   logic       data_phase;

   // flush effects are combinational; keep them quiet while in reset
   assign flush_eff = q_flush & reset;

   always_comb begin
      ale            = 1'b0;
      eu_ack         = 1'b0;
      push           = 1'b0;
      alu_op         = 3'd0;
      data_phase     = 1'b0;
      internal_rd_wr = 1'b0;

      ale    = (state == S_T1);
      eu_ack = (state == S_T4) & ~cyc_fetch;
      push   = (state == S_T4) & cyc_fetch &
               ~cyc_discard & ~flush_eff;

      if (state != S_IDLE && !cyc_fetch)
         alu_op = cyc_op;

      data_phase = (state == S_T2) | (state == S_T3) |
                   (state == S_TW) | (state == S_T4);
      internal_rd_wr = data_phase & ~cyc_fetch & cyc_wr;
   end

   assign q_en   = push;
   assign ip_en  = push | flush_eff;
   assign ip_sel = flush_eff;

   always_comb begin
      pop     = 1'b0;
      cnt_nxt = q_count;
      pop     = q_pop & (q_count != 3'd0);
      if (flush_eff)
         cnt_nxt = 3'd0;
      else
         cnt_nxt = q_count + {2'b00, push} - {2'b00, pop};
   end

   // eu_req is still high during its own ack cycle; masking it
   // with eu_ack keeps one request from launching a second transfer
   assign eu_pend    = eu_req & ~eu_ack;
   assign fetch_pend = (cnt_nxt < 3'd4) & ~q_flush;

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      unique case (state)
         S_IDLE, S_T4: begin
            if (eu_pend || fetch_pend) begin
               state_nxt = S_T1;
               start     = 1'b1;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         S_T1: state_nxt = S_T2;
         S_T2: state_nxt = S_T3;
         S_T3, S_TW: begin
            if (ready)
               state_nxt = S_T4;
            else
               state_nxt = S_TW;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cyc_fetch   <= 1'b0;
         cyc_wr      <= 1'b0;
         cyc_op      <= 3'd0;
         cyc_discard <= 1'b0;
      end else if (start) begin
         cyc_fetch   <= ~eu_pend;
         cyc_wr      <= eu_pend & eu_wr;
         cyc_op      <= eu_op;
         cyc_discard <= 1'b0;
      end else if (flush_eff && cyc_fetch &&
                   state != S_IDLE) begin
         // bytes of this fetch belong to the old stream
         cyc_discard <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_count <= 3'd0;
      end else begin
         q_count <= cnt_nxt;
      end
   end

   assign bus_state = state;
   assign q_full    = (q_count == 3'd4);
   assign q_empty   = (q_count == 3'd0);

endmodule

// File: tb/tb_bus_cycle_controller.sv
// Bench for bus_cycle_controller: directed steps plus random
// traffic, checked against a transfer-level model.
module tb_bus_cycle_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       eu_req = 1'b0;
   logic       eu_wr = 1'b0;
   logic [2:0] eu_op = 3'd0;
   logic       ready = 1'b1;
   logic       q_pop = 1'b0;
   logic       q_flush = 1'b0;
   logic [2:0] alu_op;
   logic       q_en;
   logic       ip_en;
   logic       ip_sel;
   logic       internal_rd_wr;
   logic       ale;
   logic       eu_ack;
   logic [2:0] bus_state;
   logic [2:0] q_count;
   logic       q_full;
   logic       q_empty;

   bus_cycle_controller dut (
      .clk(clk), .reset(reset), .eu_req(eu_req), .eu_wr(eu_wr),
      .eu_op(eu_op), .ready(ready), .q_pop(q_pop),
      .q_flush(q_flush), .alu_op(alu_op), .q_en(q_en),
      .ip_en(ip_en), .ip_sel(ip_sel),
      .internal_rd_wr(internal_rd_wr), .ale(ale),
      .eu_ack(eu_ack), .bus_state(bus_state),
      .q_count(q_count), .q_full(q_full), .q_empty(q_empty)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   // transfer-level model
   bit       m_busy = 0;
   bit       m_fetch = 0;
   bit       m_wr = 0;
   bit       m_disc = 0;
   bit       m_t4 = 0;
   bit       m_wait = 0;
   bit       m_ack = 0;
   int       m_step = 0;
   int       m_cnt = 0;
   logic [2:0] m_op = 3'd0;

   function automatic int mcode();
      if (!m_busy) return 0;
      if (m_t4) return 5;
      if (m_wait) return 4;
      return m_step;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_t4 = 0; m_wait = 0; m_step = 0;
      m_disc = 0; m_fetch = 0; m_cnt = 0; m_ack = 0;
   endtask

   // called at a negedge with inputs already driven
   task automatic tick();
      int code;
      int cnt_n;
      bit fl, push, pop, eu_p, pend;
      #1;
      code  = mcode();
      fl    = q_flush && reset;
      push  = (code == 5) && m_fetch && !m_disc && !fl;
      m_ack = (code == 5) && !m_fetch;
      chk("bus_state", 32'(bus_state), 32'(code));
      chk("alu_op", 32'(alu_op),
          (m_busy && !m_fetch) ? 32'(m_op) : 32'd0);
      chk("ale", 32'(ale), 32'(code == 1));
      chk("rd_wr", 32'(internal_rd_wr),
          32'(m_busy && !m_fetch && m_wr && code >= 2));
      chk("eu_ack", 32'(eu_ack), 32'(m_ack));
      chk("q_en", 32'(q_en), 32'(push));
      chk("ip_en", 32'(ip_en), 32'(push || fl));
      chk("ip_sel", 32'(ip_sel), 32'(fl));
      chk("q_count", 32'(q_count), 32'(m_cnt));
      chk("q_full", 32'(q_full), 32'(m_cnt == 4));
      chk("q_empty", 32'(q_empty), 32'(m_cnt == 0));
      if (!reset) begin
         model_reset();
      end else begin
         pop   = q_pop && m_cnt > 0;
         cnt_n = fl ? 0 : m_cnt + int'(push) - int'(pop);
         eu_p  = eu_req && !m_ack;
         pend  = eu_p || (cnt_n < 4 && !q_flush);
         if (!m_busy || m_t4) begin
            m_t4 = 0; m_wait = 0;
            if (pend) begin
               m_busy = 1; m_step = 1;
               m_fetch = !eu_p; m_wr = eu_p && eu_wr;
               m_op = eu_op; m_disc = 0;
            end else begin
               m_busy = 0;
            end
         end else begin
            if (fl && m_fetch) m_disc = 1;
            if (m_step < 3) m_step++;
            else if (ready) begin m_t4 = 1; m_wait = 0; end
            else m_wait = 1;
         end
         m_cnt = cnt_n;
      end
      @(negedge clk);
   endtask

   task automatic eu_xfer(input bit wr, input logic [2:0] op);
      int n;
      n = 0;
      eu_req = 1; eu_wr = wr; eu_op = op;
      do begin tick(); n++; end while (!m_ack && n < 40);
      chk("eu_xfer_timeout", 32'(n < 40), 32'd1);
      eu_req = 0;
   endtask

   initial begin
      int waits, c, n;
      @(negedge clk);
      // reset state
      repeat (3) tick();
      reset = 1;
      // prefetch fills the queue then idles
      repeat (20) tick();
      chk("full_after_prefetch", 32'(q_full), 32'd1);
      chk("idle_after_prefetch", 32'(bus_state), 32'd0);
      // EU write with queue full
      eu_xfer(1'b1, 3'd5);
      repeat (2) tick();
      chk("count_after_eu", 32'(q_count), 32'd4);
      // fetch with two wait states
      q_pop = 1; tick(); q_pop = 0;
      waits = 2;
      repeat (8) begin
         c = mcode();
         ready = !((c == 3 || c == 4) && waits > 0);
         if (!ready) waits--;
         tick();
      end
      ready = 1;
      // pop coincident with fetch T4
      q_pop = 1; tick(); tick(); q_pop = 0;
      tick(); tick();
      q_pop = 1; tick(); q_pop = 0;
      chk("pop_push_same", 32'(q_count), 32'd2);
      repeat (12) tick();
      // flush in T2 of a fetch with three bytes queued
      q_pop = 1; tick(); q_pop = 0;
      tick();
      q_flush = 1; tick(); q_flush = 0;
      q_pop = 1; tick(); q_pop = 0;
      chk("pop_at_empty", 32'(q_count), 32'd0);
      tick();
      chk("flush_refetch", 32'(bus_state), 32'd1);
      repeat (20) tick();
      // reset in TW of an EU write
      eu_req = 1; eu_wr = 1; eu_op = 3'd2;
      n = 0;
      while (!(mcode() == 4 && !m_fetch) && n < 40) begin
         ready = !(m_busy && !m_fetch);
         tick(); n++;
      end
      ready = 0;
      chk("reach_tw_timeout", 32'(n < 40), 32'd1);
      #1;
      chk("tw_rdwr", 32'(internal_rd_wr), 32'd1);
      reset = 0;
      #1;
      chk("rst_state", 32'(bus_state), 32'd0);
      chk("rst_ack", 32'(eu_ack), 32'd0);
      chk("rst_rdwr", 32'(internal_rd_wr), 32'd0);
      chk("rst_count", 32'(q_count), 32'd0);
      chk("rst_empty", 32'(q_empty), 32'd1);
      model_reset();
      eu_req = 0; ready = 1;
      @(negedge clk);
      repeat (2) tick();
      reset = 1;
      repeat (20) tick();
      // random traffic
      repeat (3000) begin
         if (m_ack) begin
            eu_req = 0;
         end else if (!eu_req && $urandom_range(0, 5) == 0) begin
            eu_req = 1;
            eu_wr  = 1'($urandom_range(0, 1));
            eu_op  = 3'($urandom_range(0, 7));
         end
         q_pop   = ($urandom_range(0, 2) == 0);
         q_flush = ($urandom_range(0, 15) == 0);
         ready   = ($urandom_range(0, 3) != 0);
         tick();
      end
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
